// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: widths, fetch FSM states, redirect payload
// and the redirect target arithmetic shared with decode.
package mips_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned INSTR_BYTES = 4;
   localparam int unsigned IMM_W       = 16;
   localparam int unsigned JIDX_W      = 26;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic              jump_reg;
      logic              jump;
      logic              branch_taken;
      logic [WORD_W-1:0] jr_target;
      logic [JIDX_W-1:0] jump_index;
      logic [IMM_W-1:0]  branch_imm;
   } redirect_req_t;

   // Target for the highest-priority redirect kind; branch is the fallback.
   function automatic logic [WORD_W-1:0] redirect_target(input redirect_req_t req,
                                                         input logic [WORD_W-1:0] pc4);
      logic [WORD_W-1:0] br_off;
      br_off = {{(WORD_W-IMM_W-2){req.branch_imm[IMM_W-1]}}, req.branch_imm, 2'b00};
      if (req.jump_reg)
         return req.jr_target;
      else if (req.jump)
         return {pc4[WORD_W-1:WORD_W-4], req.jump_index, 2'b00};
      else
         return pc4 + br_off;
   endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection: redirect detection, target arithmetic, legality check
// against the ROM window, and the sequential increment with end-of-ROM detect.
module next_pc_sel
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned       MEM_WORDS = 32
) (
   input  logic [WORD_W-1:0] pc,
   input  logic [WORD_W-1:0] if_pc4,
   input  logic              if_valid,
   input  redirect_req_t     req,
   output logic              redirect_c,
   output logic [WORD_W-1:0] target_c,
   output logic              target_bad_c,
   output logic [WORD_W-1:0] seq_pc_c,
   output logic              at_limit_c
);

   // One extra bit so a ROM window ending at 2^32 still compares correctly.
   localparam logic [WORD_W:0] LIMIT = (WORD_W+1)'(RESET_PC)
                                     + (WORD_W+1)'(MEM_WORDS) * (WORD_W+1)'(INSTR_BYTES);
   localparam logic [WORD_W:0] BASE  = (WORD_W+1)'(RESET_PC);

   logic [WORD_W:0] seq_wide;

   always_comb begin
      redirect_c   = if_valid & (req.jump_reg | req.jump | req.branch_taken);
      target_c     = redirect_target(req, if_pc4);
      target_bad_c = (target_c[1:0] != 2'b00)
                   || ({1'b0, target_c} < BASE)
                   || ({1'b0, target_c} >= LIMIT);
      seq_wide     = {1'b0, pc} + (WORD_W+1)'(INSTR_BYTES);
      seq_pc_c     = seq_wide[WORD_W-1:0];
      at_limit_c   = (seq_wide == LIMIT);
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, ROM addressing, IF/ID register and the
// IDLE/RUN/HALT control with redirect, stall, halt and fault handling.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned       MEM_WORDS = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [IMM_W-1:0]  branch_imm,
   input  logic              jump,
   input  logic [JIDX_W-1:0] jump_index,
   input  logic              jump_reg,
   input  logic [WORD_W-1:0] jr_target,
   input  logic              halt_req,
   output logic [WORD_W-1:0] i_addr,
   input  logic [WORD_W-1:0] i_data,
   output logic [WORD_W-1:0] if_instr,
   output logic [WORD_W-1:0] if_pc4,
   output logic              if_valid,
   output logic              halted,
   output logic              fault
);

   fetch_state_e      state, state_nxt;
   logic [WORD_W-1:0] pc, pc_nxt;
   logic [WORD_W-1:0] if_instr_nxt, if_pc4_nxt;
   logic              if_valid_nxt, halted_nxt, fault_nxt;

   redirect_req_t     req;
   logic              redirect_c, target_bad_c, at_limit_c;
   logic [WORD_W-1:0] target_c, seq_pc_c;

   assign req = '{jump_reg:     jump_reg,
                  jump:         jump,
                  branch_taken: branch_taken,
                  jr_target:    jr_target,
                  jump_index:   jump_index,
                  branch_imm:   branch_imm};

   next_pc_sel #(
      .RESET_PC  (RESET_PC),
      .MEM_WORDS (MEM_WORDS)
   ) u_next_pc_sel (
      .pc           (pc),
      .if_pc4       (if_pc4),
      .if_valid     (if_valid),
      .req          (req),
      .redirect_c   (redirect_c),
      .target_c     (target_c),
      .target_bad_c (target_bad_c),
      .seq_pc_c     (seq_pc_c),
      .at_limit_c   (at_limit_c)
   );

   // ROM is combinational, so the PC itself is the fetch address.
   assign i_addr = pc;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         pc       <= RESET_PC;
         if_instr <= '0;
         if_pc4   <= '0;
         if_valid <= 1'b0;
         halted   <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         if_instr <= if_instr_nxt;
         if_pc4   <= if_pc4_nxt;
         if_valid <= if_valid_nxt;
         halted   <= halted_nxt;
         fault    <= fault_nxt;
      end
   end

   // Priority in RUN: halt, illegal redirect, redirect, stall, sequential fetch.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      if_instr_nxt = if_instr;
      if_pc4_nxt   = if_pc4;
      if_valid_nxt = if_valid;
      halted_nxt   = halted;
      fault_nxt    = fault;

      case (state)
         ST_IDLE: begin
            if_valid_nxt = 1'b0;
            state_nxt    = ST_RUN;
         end
         ST_RUN: begin
            if (halt_req) begin
               if_valid_nxt = 1'b0;
               halted_nxt   = 1'b1;
               state_nxt    = ST_HALT;
            end else if (redirect_c && target_bad_c) begin
               if_valid_nxt = 1'b0;
               halted_nxt   = 1'b1;
               fault_nxt    = 1'b1;
               state_nxt    = ST_HALT;
            end else if (redirect_c) begin
               pc_nxt       = target_c;
               if_valid_nxt = 1'b0;
            end else if (!stall) begin
               if_instr_nxt = i_data;
               if_pc4_nxt   = seq_pc_c;
               if_valid_nxt = 1'b1;
               if (at_limit_c) begin
                  halted_nxt = 1'b1;
                  state_nxt  = ST_HALT;
               end else begin
                  pc_nxt = seq_pc_c;
               end
            end
         end
         ST_HALT: begin
            if_valid_nxt = 1'b0;
            halted_nxt   = 1'b1;
         end
         default: begin
            if_valid_nxt = 1'b0;
            state_nxt    = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; ROM word k holds the value k.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stall, branch_taken, jump, jump_reg, halt_req;
   logic [15:0] branch_imm;
   logic [25:0] jump_index;
   logic [31:0] jr_target, i_addr, i_data, if_instr, if_pc4;
   logic        if_valid, halted, fault;

   int tests = 0;
   int fails = 0;

   fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(32)) dut (
      .clock(clock), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
      .branch_imm(branch_imm), .jump(jump), .jump_index(jump_index), .jump_reg(jump_reg),
      .jr_target(jr_target), .halt_req(halt_req), .i_addr(i_addr), .i_data(i_data),
      .if_instr(if_instr), .if_pc4(if_pc4), .if_valid(if_valid), .halted(halted),
      .fault(fault)
   );

   always #5 clock = ~clock;

   assign i_data = {2'b00, i_addr[31:2]};

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs;
      stall = 0; branch_taken = 0; jump = 0; jump_reg = 0; halt_req = 0;
      branch_imm = '0; jump_index = '0; jr_target = '0;
   endtask

   task automatic apply_reset;
      clear_inputs();
      reset_n = 0;
      repeat (2) @(negedge clock);
      reset_n = 1;
   endtask

   task automatic test_reset;
      clear_inputs();
      reset_n = 0;
      #12;
      tests++; if (i_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got %h exp %h", i_addr, 32'h0); end
      tests++; if (if_instr !== 32'h0 || if_pc4 !== 32'h0) begin fails++; $display("FAIL rst_ifid got %h/%h exp 0/0", if_instr, if_pc4); end
      tests++; if ({if_valid, halted, fault} !== 3'b000) begin fails++; $display("FAIL rst_flags got %b exp 000", {if_valid, halted, fault}); end
      @(negedge clock); reset_n = 1;
      step();
      tests++; if (i_addr !== 32'h0 || if_valid !== 1'b0) begin fails++; $display("FAIL idle got addr %h v %b exp 0 0", i_addr, if_valid); end
      step();
      tests++; if (if_instr !== 32'd0 || if_pc4 !== 32'h4 || if_valid !== 1'b1 || i_addr !== 32'h4) begin fails++; $display("FAIL fetch0 got %h %h %b %h exp 0 4 1 4", if_instr, if_pc4, if_valid, i_addr); end
      step();
      tests++; if (if_instr !== 32'd1 || i_addr !== 32'h8) begin fails++; $display("FAIL fetch1 got %h %h exp 1 8", if_instr, i_addr); end
   endtask

   task automatic test_stall;
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++; if (i_addr !== 32'h8 || if_instr !== 32'd1 || if_pc4 !== 32'h8) begin fails++; $display("FAIL stall_hold%0d got %h %h %h exp 8 1 8", i, i_addr, if_instr, if_pc4); end
      end
      stall = 0;
      step();
      tests++; if (if_instr !== 32'd2 || if_pc4 !== 32'hC || i_addr !== 32'hC) begin fails++; $display("FAIL stall_resume got %h %h %h exp 2 c c", if_instr, if_pc4, i_addr); end
   endtask

   task automatic test_branch;
      step();
      tests++; if (if_pc4 !== 32'h10 || if_instr !== 32'd3) begin fails++; $display("FAIL br_setup got %h %h exp 10 3", if_pc4, if_instr); end
      branch_taken = 1; branch_imm = 16'hFFFE;
      step();
      clear_inputs();
      tests++; if (i_addr !== 32'h8 || if_valid !== 1'b0) begin fails++; $display("FAIL br_redirect got %h %b exp 8 0", i_addr, if_valid); end
      step();
      tests++; if (if_instr !== 32'd2 || if_pc4 !== 32'hC || if_valid !== 1'b1 || i_addr !== 32'hC) begin fails++; $display("FAIL br_refetch got %h %h %b %h exp 2 c 1 c", if_instr, if_pc4, if_valid, i_addr); end
   endtask

   task automatic test_jump;
      jump = 1; branch_taken = 1; branch_imm = 16'h0004; jump_index = 26'd5; stall = 1;
      step();
      tests++; if (i_addr !== 32'h14 || if_valid !== 1'b0) begin fails++; $display("FAIL jmp_prio got %h %b exp 14 0", i_addr, if_valid); end
      branch_taken = 0; stall = 0; jump_index = 26'd9;
      step();
      clear_inputs();
      tests++; if (if_instr !== 32'd5 || if_pc4 !== 32'h18 || i_addr !== 32'h18) begin fails++; $display("FAIL jmp_ignored got %h %h %h exp 5 18 18", if_instr, if_pc4, i_addr); end
   endtask

   task automatic test_fault;
      jump_reg = 1; jr_target = 32'h6;
      step();
      clear_inputs();
      tests++; if ({fault, halted, if_valid} !== 3'b110 || i_addr !== 32'h18) begin fails++; $display("FAIL jr_misalign got %b %h exp 110 18", {fault, halted, if_valid}, i_addr); end
      step(); step();
      tests++; if (i_addr !== 32'h18 || {fault, halted} !== 2'b11 || if_instr !== 32'd5) begin fails++; $display("FAIL fault_frozen got %h %b %h exp 18 11 5", i_addr, {fault, halted}, if_instr); end
      @(negedge clock); #2; reset_n = 0; #1;
      tests++; if (i_addr !== 32'h0 || {fault, halted, if_valid} !== 3'b000 || if_instr !== 32'h0) begin fails++; $display("FAIL fault_async_rst got %h %b %h exp 0 000 0", i_addr, {fault, halted, if_valid}, if_instr); end
      @(negedge clock); reset_n = 1;
   endtask

   task automatic test_range;
      branch_taken = 1; branch_imm = 16'h7FFF;
      step();
      clear_inputs();
      tests++; if (fault !== 1'b0 || i_addr !== 32'h0) begin fails++; $display("FAIL idle_redirect got %b %h exp 0 0", fault, i_addr); end
      step();
      tests++; if (if_valid !== 1'b1 || if_pc4 !== 32'h4 || i_addr !== 32'h4) begin fails++; $display("FAIL range_setup got %b %h %h exp 1 4 4", if_valid, if_pc4, i_addr); end
      jump_reg = 1; jr_target = 32'h80;
      step();
      clear_inputs();
      tests++; if ({fault, halted, if_valid} !== 3'b110 || i_addr !== 32'h4) begin fails++; $display("FAIL jr_range got %b %h exp 110 4", {fault, halted, if_valid}, i_addr); end
      apply_reset();
   endtask

   task automatic test_halt_req;
      step(); step();
      halt_req = 1; stall = 1; jump = 1; jump_index = 26'd3;
      step();
      clear_inputs();
      tests++; if ({fault, halted, if_valid} !== 3'b010 || i_addr !== 32'h4) begin fails++; $display("FAIL halt_req got %b %h exp 010 4", {fault, halted, if_valid}, i_addr); end
      step();
      tests++; if (i_addr !== 32'h4 || if_instr !== 32'd0 || if_pc4 !== 32'h4 || halted !== 1'b1) begin fails++; $display("FAIL halt_frozen got %h %h %h %b exp 4 0 4 1", i_addr, if_instr, if_pc4, halted); end
      apply_reset();
   endtask

   task automatic test_limit;
      step();
      for (int i = 0; i < 31; i++) step();
      tests++; if (i_addr !== 32'h7C || if_instr !== 32'd30 || halted !== 1'b0) begin fails++; $display("FAIL lim_approach got %h %h %b exp 7c 1e 0", i_addr, if_instr, halted); end
      step();
      tests++; if (if_instr !== 32'd31 || if_pc4 !== 32'h80 || i_addr !== 32'h7C || {halted, fault} !== 2'b10) begin fails++; $display("FAIL lim_last got %h %h %h %b exp 1f 80 7c 10", if_instr, if_pc4, i_addr, {halted, fault}); end
      step();
      tests++; if (if_valid !== 1'b0 || i_addr !== 32'h7C || if_instr !== 32'd31 || halted !== 1'b1) begin fails++; $display("FAIL lim_halted got %b %h %h %b exp 0 7c 1f 1", if_valid, i_addr, if_instr, halted); end
      @(negedge clock); #2; reset_n = 0; #1;
      tests++; if (i_addr !== 32'h0 || halted !== 1'b0 || fault !== 1'b0) begin fails++; $display("FAIL lim_async_rst got %h %b %b exp 0 0 0", i_addr, halted, fault); end
      @(negedge clock); reset_n = 1;
   endtask

   initial begin
      test_reset();
      test_stall();
      test_branch();
      test_jump();
      test_fault();
      test_range();
      test_halt_req();
      test_limit();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
